// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths and the target receiver state set.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    WAIT_STOP
  } i2c_tgt_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for an asynchronous bus line, with single-cycle rise/fall strobes.
module i2c_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to 1 so an idle (pulled-up) bus produces no spurious edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver: START/STOP detection, address match, byte delivery with ACK/NACK.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] DEV_ADDR    = 7'h55,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  input  logic                  rx_ready,
  output logic [I2C_DATA_W-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  stop_det
);

  logic s_scl, scl_rise, scl_fall;
  logic s_sda, sda_rise, sda_fall;
  logic start_c, stop_c;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (scl_in),
    .q_o    (s_scl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (sda_in),
    .q_o    (s_sda),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  assign start_c = sda_fall & s_scl;
  assign stop_c  = sda_rise & s_scl;

  i2c_tgt_state_e        state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [I2C_DATA_W-1:0] shift_q, shift_d;
  logic                  done_q, done_d;
  logic                  armed_q, armed_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  busy_q, busy_d;
  logic [I2C_DATA_W-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  stop_q, stop_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
      armed_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      armed_q    <= armed_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      stop_q     <= stop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    done_d     = done_q;
    armed_d    = armed_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    stop_d     = 1'b0;

    if (stop_c) begin
      state_d  = IDLE;
      cnt_d    = '0;
      done_d   = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      stop_d   = 1'b1;
    end else if (start_c) begin
      // busy is left alone here; the address decision of the new transfer settles it.
      state_d  = ADDR;
      cnt_d    = '0;
      done_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[I2C_DATA_W-2:0], s_sda};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) done_d = 1'b1;
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (shift_q[I2C_DATA_W-1:1] == DEV_ADDR && !shift_q[0]) begin
              state_d  = ADDR_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            state_d  = DATA;
            sda_oe_d = 1'b0;
            cnt_d    = '0;
          end
        end
        DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[I2C_DATA_W-2:0], s_sda};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              done_d  = 1'b1;
              armed_d = rx_ready;
              if (rx_ready) begin
                data_out_d = {shift_q[I2C_DATA_W-2:0], s_sda};
                valid_d    = 1'b1;
              end
            end
          end else if (scl_fall && done_q) begin
            done_d   = 1'b0;
            state_d  = DATA_ACK;
            sda_oe_d = armed_q;
          end
        end
        DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = armed_q ? DATA : WAIT_STOP;
          end
        end
        WAIT_STOP: sda_oe_d = 1'b0;
        default:   state_d  = IDLE;
      endcase
    end
  end

  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign stop_det   = stop_q;

endmodule
